// File: rtl/barrel_shift_pkg.sv
// ============================================================================
//  Module      : barrel_shift_pkg
//  Description : Shared mode encoding and width check for barrel_shift_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package barrel_shift_pkg;

    typedef enum logic [1:0] {
        BS_SLL = 2'b00,
        BS_SRL = 2'b01,
        BS_SRA = 2'b10,
        BS_ROL = 2'b11
    } bs_mode_t;

    // Data width must be a power of two and at least 4 bits.
    function automatic bit bs_width_ok(input int width);
        return (width >= 4) && ((width & (width - 1)) == 0);
    endfunction

endpackage : barrel_shift_pkg

`default_nettype wire

// File: rtl/barrel_shift_stage.sv
// ============================================================================
//  Module      : barrel_shift_stage
//  Description : One registered log2 stage: shift by SHIFT or pass through,
//                with valid/ready hold. Rotate honoured when
//                BARREL_SHIFT_ROTATE_EN is defined, otherwise ROL acts as SLL.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int SHIFT   = 1,
    localparam int AW      = $clog2(WIDTH),
    localparam int SEL_BIT = $clog2(SHIFT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  bs_mode_t         mode_i,
    input  logic [AW-1:0]    amt_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output bs_mode_t         mode_o,
    output logic [AW-1:0]    amt_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    bs_mode_t         mode_q;
    logic [AW-1:0]    amt_q;
    logic [AW-1:0]    amt_d;
    logic             w_load;

    // An empty slot always loads, so bubbles collapse toward the output.
    assign w_load  = !valid_q || ready_i;
    assign ready_o = w_load;

    always_comb begin
        data_d = data_i;
        if (amt_i[SEL_BIT]) begin
            case (mode_i)
                BS_SRL: data_d = {{SHIFT{1'b0}}, data_i[WIDTH-1:SHIFT]};
                BS_SRA: data_d = {{SHIFT{data_i[WIDTH-1]}}, data_i[WIDTH-1:SHIFT]};
`ifdef BARREL_SHIFT_ROTATE_EN
                BS_ROL: data_d = {data_i[WIDTH-SHIFT-1:0], data_i[WIDTH-1:WIDTH-SHIFT]};
`endif
                default: data_d = {data_i[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
            endcase
        end
    end

    always_comb begin
        amt_d          = amt_i;
        amt_d[SEL_BIT] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= BS_SLL;
            amt_q   <= '0;
        end else if (w_load) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_d;
                mode_q <= mode_i;
                amt_q  <= amt_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign mode_o  = mode_q;
    assign amt_o   = amt_q;

endmodule : barrel_shift_stage

`default_nettype wire

// File: rtl/barrel_shift_pipe.sv
// ============================================================================
//  Module      : barrel_shift_pipe
//  Description : Pipelined WIDTH-bit barrel shifter (SLL/SRL/SRA/ROL), one
//                log2 stage per slot, valid/ready flow control.
//                Optional macro: BARREL_SHIFT_ROTATE_EN enables mode 11 = ROL.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    if (!bs_width_ok(WIDTH)) begin : g_width_check
        $error("barrel_shift_pipe: WIDTH must be a power of two >= 4");
    end

    // Index k is the input side of stage k; index AW is the pipe output.
    logic [AW:0]      w_valid;
    logic [AW:0]      w_ready;
    logic [WIDTH-1:0] w_data [AW+1];
    bs_mode_t         w_mode [AW+1];
    logic [AW-1:0]    w_amt  [AW+1];
    logic             w_unused;

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_mode[0]  = bs_mode_t'(in_mode);
    assign w_amt[0]   = in_amt;
    assign w_ready[AW] = out_ready;
    assign in_ready   = w_ready[0];

    for (genvar k = 0; k < AW; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (w_valid[k]),
            .ready_o (w_ready[k]),
            .data_i  (w_data[k]),
            .mode_i  (w_mode[k]),
            .amt_i   (w_amt[k]),
            .valid_o (w_valid[k+1]),
            .ready_i (w_ready[k+1]),
            .data_o  (w_data[k+1]),
            .mode_o  (w_mode[k+1]),
            .amt_o   (w_amt[k+1])
        );
    end

    assign out_valid = w_valid[AW];
    assign out_data  = w_data[AW];
    assign out_zero  = ~|w_data[AW];

    // Mode and residual amount are fully consumed by the last stage.
    assign w_unused = ^{w_mode[AW], w_amt[AW]};

endmodule : barrel_shift_pipe

`default_nettype wire

// File: tb/tb_barrel_shift_pipe.sv
// ============================================================================
//  Module      : tb_barrel_shift_pipe
//  Description : Scoreboard bench for barrel_shift_pipe at WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_amt = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_zero;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    barrel_shift_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] a,
                                          input logic [1:0] m);
        logic [15:0] r;
        case (m)
            2'b01:   r = d >> a;
            2'b10:   r = $signed(d) >>> a;
`ifdef BARREL_SHIFT_ROTATE_EN
            2'b11:   r = (d << a) | (d >> (5'd16 - {1'b0, a}));
`endif
            default: r = d << a;
        endcase
        return r;
    endfunction

    // Drive one cycle at the falling edge, then sample settled outputs.
    task automatic step(input bit iv, input logic [15:0] d, input logic [3:0] a,
                        input logic [1:0] m, input bit ordy,
                        output bit ifire, output bit ir, output bit ov, output bit ofire,
                        output logic [15:0] od, output logic oz);
        @(negedge clk);
        in_valid = iv; in_data = d; in_amt = a; in_mode = m; out_ready = ordy;
        #1;
        ir = in_ready; ifire = iv && in_ready;
        ov = out_valid; ofire = out_valid && ordy;
        od = out_data; oz = out_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        if (out_zero !== 1'b1) begin failures++; $display("FAIL reset_out_zero got=%b exp=1", out_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_srl_sweep();
        bit ifire, ir, ov, ofire, oz;
        logic [15:0] od, e;
        int n_in, n_out, first_in, first_out, last_out;
        n_in = 0; n_out = 0; first_in = -1; first_out = -1; last_out = -1;
        for (int c = 0; c < 60 && n_out < 16; c++) begin
            step(n_in < 16, 16'h8000, 4'(n_in), 2'b01, 1'b1, ifire, ir, ov, ofire, od, oz);
            if (ofire) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                if (od !== e) begin failures++; $display("FAIL srl_sweep[%0d] got=%h exp=%h", n_out, od, e); end
                if (first_out < 0) first_out = c;
                last_out = c;
                n_out++;
            end
            if (ifire) begin
                exp_q.push_back(16'h8000 >> n_in);
                if (first_in < 0) first_in = c;
                n_in++;
            end
        end
        checks += 3;
        if (n_out != 16) begin failures++; $display("FAIL srl_count got=%0d exp=16", n_out); end
        if (first_out - first_in != 4) begin failures++; $display("FAIL srl_latency got=%0d exp=4", first_out - first_in); end
        if (last_out - first_out != 15) begin failures++; $display("FAIL srl_rate got=%0d exp=15", last_out - first_out); end
        exp_q.delete();
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [15:0] d;
        logic [3:0]  a;
        logic [15:0] e;
    } vec_t;

    task automatic test_modes();
        bit ifire, ir, ov, ofire, oz, want_in;
        logic [15:0] od, e;
        vec_t v [10];
        int n_in, n_out;
        v[0] = '{2'b10, 16'h8000, 4'd4,  16'hF800};
        v[1] = '{2'b10, 16'h4000, 4'd4,  16'h0400};
        v[2] = '{2'b00, 16'h00FF, 4'd8,  16'hFF00};
        v[3] = '{2'b00, 16'h8000, 4'd1,  16'h0000};
`ifdef BARREL_SHIFT_ROTATE_EN
        v[4] = '{2'b11, 16'h8001, 4'd1,  16'h0003};
`else
        v[4] = '{2'b11, 16'h8001, 4'd1,  16'h0002};
`endif
        v[5] = '{2'b11, 16'h8001, 4'd0,  16'h8001};
        v[6] = '{2'b01, 16'hFFFF, 4'd15, 16'h0001};
        v[7] = '{2'b10, 16'h8000, 4'd15, 16'hFFFF};
        v[8] = '{2'b10, 16'h1234, 4'd0,  16'h1234};
        v[9] = '{2'b00, 16'hA5A5, 4'd15, 16'h8000};
        n_in = 0; n_out = 0;
        for (int c = 0; c < 80 && n_out < 10; c++) begin
            want_in = (n_in < 10) && ($urandom_range(0, 3) != 0);
            if (n_in < 10)
                step(want_in, v[n_in].d, v[n_in].a, v[n_in].m, 1'b1, ifire, ir, ov, ofire, od, oz);
            else
                step(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, ifire, ir, ov, ofire, od, oz);
            if (ofire) begin
                checks += 2;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                if (od !== e) begin failures++; $display("FAIL mode_data[%0d] got=%h exp=%h", n_out, od, e); end
                if (oz !== (e == 16'h0)) begin failures++; $display("FAIL mode_zero[%0d] got=%b exp=%b", n_out, oz, e == 16'h0); end
                n_out++;
            end
            if (ifire) begin
                exp_q.push_back(v[n_in].e);
                n_in++;
            end
        end
        checks++;
        if (n_out != 10) begin failures++; $display("FAIL mode_count got=%0d exp=10", n_out); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit ifire, ir, ov, ofire, oz, ordy, prev_stall;
        logic [15:0] od, e, prev_od;
        logic [15:0] sd [8];
        logic [3:0]  sa [8];
        logic [1:0]  sm [8];
        int n_in, n_out;
        for (int i = 0; i < 8; i++) begin
            sd[i] = 16'($urandom);
            sa[i] = 4'($urandom_range(0, 15));
            sm[i] = 2'($urandom_range(0, 3));
        end
        n_in = 0; n_out = 0; prev_stall = 1'b0; prev_od = '0;
        for (int c = 0; c < 150 && n_out < 8; c++) begin
            ordy = (c < 6) ? 1'b0 : 1'($urandom_range(0, 1));
            if (n_in < 8)
                step(1'b1, sd[n_in], sa[n_in], sm[n_in], ordy, ifire, ir, ov, ofire, od, oz);
            else
                step(1'b0, 16'h0, 4'h0, 2'b00, ordy, ifire, ir, ov, ofire, od, oz);
            if (c == 4 || c == 5) begin
                checks += 2;
                if (ir !== 1'b0) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, ir); end
                if (n_in != 4) begin failures++; $display("FAIL bp_held c=%0d got=%0d exp=4", c, n_in); end
            end
            if (prev_stall) begin
                checks++;
                if (ov !== 1'b1 || od !== prev_od) begin
                    failures++;
                    $display("FAIL bp_stable c=%0d got=%b/%h exp=1/%h", c, ov, od, prev_od);
                end
            end
            if (ofire) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                if (od !== e) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", n_out, od, e); end
                n_out++;
            end
            if (ifire) begin
                exp_q.push_back(model(sd[n_in], sa[n_in], sm[n_in]));
                n_in++;
            end
            prev_stall = ov && !ordy;
            prev_od = od;
        end
        checks++;
        if (n_out != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", n_out); end
        exp_q.delete();
    endtask

    task automatic test_reset_flush();
        bit ifire, ir, ov, ofire, oz;
        logic [15:0] od;
        int n_in, seen, acc_c, out_c;
        n_in = 0; seen = 0; acc_c = -1; out_c = -1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h00F0 + 16'(i), 4'd2, 2'b00, 1'b1, ifire, ir, ov, ofire, od, oz);
            if (ifire) n_in++;
            if (ofire) seen++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (n_in != 3) begin failures++; $display("FAIL flush_accepts got=%0d exp=3", n_in); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        if (out_data !== 16'h0) begin failures++; $display("FAIL flush_out_data got=%h exp=0000", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 16'h0, 4'h0, 2'b00, 1'b1, ifire, ir, ov, ofire, od, oz);
            if (ofire) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL flush_leak got=%0d exp=0", seen); end
        for (int c = 0; c < 20 && out_c < 0; c++) begin
            step(acc_c < 0, 16'h0001, 4'd3, 2'b00, 1'b1, ifire, ir, ov, ofire, od, oz);
            if (ofire) begin
                out_c = c;
                checks++;
                if (od !== 16'h0008) begin failures++; $display("FAIL flush_next_data got=%h exp=0008", od); end
            end
            if (ifire) acc_c = c;
        end
        checks++;
        if (out_c - acc_c != 4 || out_c < 0) begin
            failures++;
            $display("FAIL flush_next_latency got=%0d exp=4", out_c - acc_c);
        end
    endtask

    initial begin
        test_reset();
        test_srl_sweep();
        test_modes();
        test_backpressure();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_barrel_shift_pipe

`default_nettype wire
